// File: rtl/detect_pkg.sv
// Shared types and constants for the detection result / beeper stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package detect_pkg;

  // Controller states; the fourth 2-bit code is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BEEP    = 2'b01,
    ST_HOLDOFF = 2'b10
  } state_e;

  // Timer and tone counter width.
  localparam int CNT_W  = 32;
  // Consecutive-positive run counter width (CONFIRM is 1..15).
  localparam int RUN_W  = 4;
  // Detection counter width.
  localparam int DCNT_W = 8;

  // Default timing for a 50 MHz core clock.
  localparam int unsigned DEF_CONFIRM        = 2;
  localparam int unsigned DEF_TONE_HALF      = 6250;        // 4 kHz tone
  localparam int unsigned DEF_BEEP_CYCLES    = 50_000_000;  // 1 s of tone
  localparam int unsigned DEF_HOLDOFF_CYCLES = 5_000_000;   // 100 ms quiet

  // Saturating increment for the detection counter: sticks at all-ones.
  function automatic logic [DCNT_W-1:0] sat_inc(input logic [DCNT_W-1:0] v);
    return (v == '1) ? v : v + DCNT_W'(1);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Enable-gated square-wave generator; output starts high for one full half-period.
// Latency: tone_o goes high on the same edge en_i is first seen high; low on the edge en_i is seen low.
// Backpressure: none; free-running while enabled, cleared when disabled.
module tone_gen
  import detect_pkg::*;
#(
  parameter int unsigned TONE_HALF = DEF_TONE_HALF
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tone_o
);

  // Counter value at which the half-period ends and the output flips.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(TONE_HALF - 1);

  logic             en_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;

  // Next tone state: clear when disabled, restart high on enable rise, else count and flip on wrap.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (!en_i) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (!en_q) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (cnt_q == HALF_LAST) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Tone registers; async reset forces the piezo drive low immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q   <= 1'b0;
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      en_q   <= en_i;
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/detect_beep_ctrl.sv
// Qualifies DP match frames (CONFIRM in a row), then beeps for a fixed time and holds off before re-arming.
// Latency: busy/beep/detect_count update on the edge that samples the qualifying strobe; LEDs 1 cycle.
// Backpressure: none; strobes outside IDLE only update led_detect and are otherwise dropped.
module detect_beep_ctrl
  import detect_pkg::*;
#(
  parameter int unsigned CONFIRM        = DEF_CONFIRM,
  parameter int unsigned TONE_HALF      = DEF_TONE_HALF,
  parameter int unsigned BEEP_CYCLES    = DEF_BEEP_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              result_dv,
  input  logic              result,
  input  logic              vad_in,
  output logic              beep,
  output logic              led_detect,
  output logic              led_vad,
  output logic              busy,
  output logic [DCNT_W-1:0] detect_count
);

  // Terminal counts, resolved at elaboration so the compares are plain equality.
  localparam logic [RUN_W-1:0] CONFIRM_L = RUN_W'(CONFIRM);
  localparam logic [CNT_W-1:0] BEEP_LAST = CNT_W'(BEEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_e              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [DCNT_W-1:0]   count_q, count_d;
  logic                busy_q, busy_d;
  logic                led_det_q, led_det_d;
  logic                vad_q;
  logic                pos_strobe;
  logic                vad_fall;
  logic                trigger;
  logic                tone_en;

  // State register; reset lands in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: qualify in IDLE, then time out BEEP and HOLDOFF; unknown codes fall back to IDLE.
  always_comb begin
    pos_strobe = result_dv & result;
    // A voice-activity drop ends the utterance, so it vetoes any pending run.
    vad_fall   = vad_q & ~vad_in;
    trigger    = 1'b0;
    state_d    = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pos_strobe && !vad_fall && ((run_q + RUN_W'(1)) == CONFIRM_L)) begin
          trigger = 1'b1;
          state_d = ST_BEEP;
        end
      end
      ST_BEEP: begin
        if (timer_q == BEEP_LAST) begin
          state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (timer_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs derived from the next state so that busy and the tone are registered yet aligned with it.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    tone_en = (state_d == ST_BEEP);
  end

  // Run counter, phase timer, detection count and LED next values.
  always_comb begin
    run_d     = run_q;
    timer_d   = timer_q;
    count_d   = count_q;
    led_det_d = led_det_q;

    // The run only accumulates while armed; it is parked at zero otherwise.
    if (state_q != ST_IDLE || trigger || vad_fall) begin
      run_d = '0;
    end else if (result_dv) begin
      run_d = result ? (run_q + RUN_W'(1)) : '0;
    end

    // Timer counts cycles spent in the current timed phase and restarts on every state change.
    if (state_d != state_q || state_q == ST_IDLE) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end

    if (trigger) begin
      count_d = sat_inc(count_q);
    end

    // The detect LED mirrors every result regardless of state.
    if (result_dv) begin
      led_det_d = result;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q     <= '0;
      timer_q   <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      led_det_q <= 1'b0;
      vad_q     <= 1'b0;
    end else begin
      run_q     <= run_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      led_det_q <= led_det_d;
      vad_q     <= vad_in;
    end
  end

  tone_gen #(
    .TONE_HALF (TONE_HALF)
  ) u_tone (
    .clk    (clk),
    .reset  (reset),
    .en_i   (tone_en),
    .tone_o (beep)
  );

  assign led_detect   = led_det_q;
  assign led_vad      = vad_q;
  assign busy         = busy_q;
  assign detect_count = count_q;

endmodule

// File: tb/tb_detect_beep_ctrl.sv
// Bench for detect_beep_ctrl: directed vectors, a timeline model and per-cycle output compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_detect_beep_ctrl;

  localparam int CONFIRM   = 2;
  localparam int TONE_HALF = 3;
  localparam int BEEP_CYC  = 20;
  localparam int HOLD_CYC  = 10;
  // Expected beep after the trigger edge, one entry per cycle of tone.
  localparam bit [0:19] PAT = 20'b11100011100011100011;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       result_dv = 1'b0;
  logic       result    = 1'b0;
  logic       vad_in    = 1'b0;
  logic       beep;
  logic       led_detect;
  logic       led_vad;
  logic       busy;
  logic [7:0] detect_count;

  int checks = 0;
  int errors = 0;

  detect_beep_ctrl #(
    .CONFIRM        (CONFIRM),
    .TONE_HALF      (TONE_HALF),
    .BEEP_CYCLES    (BEEP_CYC),
    .HOLDOFF_CYCLES (HOLD_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .result_dv    (result_dv),
    .result       (result),
    .vad_in       (vad_in),
    .beep         (beep),
    .led_detect   (led_detect),
    .led_vad      (led_vad),
    .busy         (busy),
    .detect_count (detect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: remembers the edge index of the last trigger; everything else follows from elapsed time.
  int m_cyc      = 0;
  int m_trig     = 0;
  int m_run      = 0;
  int m_cnt      = 0;
  bit m_trig_vld = 1'b0;
  bit m_led_det  = 1'b0;
  bit m_vad      = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cyc      = 0;
      m_trig     = 0;
      m_run      = 0;
      m_cnt      = 0;
      m_trig_vld = 1'b0;
      m_led_det  = 1'b0;
      m_vad      = 1'b0;
    end else begin
      m_cyc = m_cyc + 1;
      // Armed when no tone has happened yet or the tone plus quiet time is fully over.
      if (!m_trig_vld || (m_cyc - m_trig) > BEEP_CYC + HOLD_CYC) begin
        if (m_vad && !vad_in) begin
          m_run = 0;
        end else if (result_dv && result) begin
          if (m_run + 1 == CONFIRM) begin
            m_trig_vld = 1'b1;
            m_trig     = m_cyc;
            m_run      = 0;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
          end else begin
            m_run = m_run + 1;
          end
        end else if (result_dv) begin
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (result_dv) m_led_det = result;
      m_vad = vad_in;
    end
  end

  // Per-cycle compare of every output against the model.
  int cmp_age;
  bit cmp_beep;
  bit cmp_busy;

  always @(negedge clk) begin
    cmp_age  = m_cyc - m_trig;
    cmp_beep = m_trig_vld && cmp_age < BEEP_CYC && ((cmp_age / TONE_HALF) % 2 == 0);
    cmp_busy = m_trig_vld && cmp_age < BEEP_CYC + HOLD_CYC;
    chk("beep",         32'(beep),         32'(cmp_beep));
    chk("busy",         32'(busy),         32'(cmp_busy));
    chk("led_detect",   32'(led_detect),   32'(m_led_det));
    chk("led_vad",      32'(led_vad),      32'(m_vad));
    chk("detect_count", 32'(detect_count), 32'(m_cnt));
  end

  // One clock of input: applied at the falling edge, sampled by the next rising edge.
  task automatic cyc_in(input bit dv, input bit res);
    @(negedge clk);
    result_dv = dv;
    result    = res;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    result_dv = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    // Power-on reset state.
    #3;
    chk("por_beep",  32'(beep),         32'd0);
    chk("por_busy",  32'(busy),         32'd0);
    chk("por_ldet",  32'(led_detect),   32'd0);
    chk("por_lvad",  32'(led_vad),      32'd0);
    chk("por_count", 32'(detect_count), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    vad_in = 1'b1;

    // 1: asynchronous reset while beeping.
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b0, 1'b0);
    chk("s1_beep_pre",  32'(beep),         32'd1);
    chk("s1_busy_pre",  32'(busy),         32'd1);
    chk("s1_count_pre", 32'(detect_count), 32'd1);
    chk("s1_ldet_pre",  32'(led_detect),   32'd1);
    chk("s1_lvad_pre",  32'(led_vad),      32'd1);
    #2 reset = 1'b0;
    #1;
    chk("s1_beep_rst",  32'(beep),         32'd0);
    chk("s1_busy_rst",  32'(busy),         32'd0);
    chk("s1_ldet_rst",  32'(led_detect),   32'd0);
    chk("s1_lvad_rst",  32'(led_vad),      32'd0);
    chk("s1_count_rst", 32'(detect_count), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;

    // 2: two positive strobes five cycles apart, full tone and holdoff timeline.
    do_reset();
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b1);
    repeat (4) cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b1);
    for (int k = 0; k < 30; k++) begin
      cyc_in(1'b0, 1'b0);
      if (k < 20) chk("s2_beep_tone", 32'(beep), 32'(PAT[k]));
      else        chk("s2_beep_hold", 32'(beep), 32'd0);
      chk("s2_busy", 32'(busy), 32'd1);
    end
    cyc_in(1'b0, 1'b0);
    chk("s2_busy_end",  32'(busy),         32'd0);
    chk("s2_count",     32'(detect_count), 32'd1);

    // 3: a negative frame breaks the run.
    do_reset();
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b0);
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    chk("s3_busy_run1", 32'(busy), 32'd0);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    chk("s3_busy_trig", 32'(busy),         32'd1);
    chk("s3_count",     32'(detect_count), 32'd1);

    // 4: voice activity dropping clears the run.
    do_reset();
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    vad_in = 1'b0;
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    chk("s4_busy_cleared", 32'(busy), 32'd0);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    chk("s4_busy_trig", 32'(busy),         32'd1);
    chk("s4_count",     32'(detect_count), 32'd1);
    vad_in = 1'b1;

    // 5: strobes during BEEP/HOLDOFF (incl. the exit edge) are ignored.
    do_reset();
    cyc_in(1'b0, 1'b0);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b1, 1'b1);
    for (int k = 1; k <= 35; k++) begin
      cyc_in((k == 3 || k == 6 || k == 10 || k == 22 || k == 30), (k != 6));
      if (k == 4)  chk("s5_ldet_pos", 32'(led_detect), 32'd1);
      if (k == 7)  chk("s5_ldet_neg", 32'(led_detect), 32'd0);
      if (k == 11) chk("s5_ldet_re",  32'(led_detect), 32'd1);
    end
    chk("s5_busy_idle", 32'(busy),         32'd0);
    chk("s5_count_1",   32'(detect_count), 32'd1);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    chk("s5_busy_first", 32'(busy), 32'd0);
    cyc_in(1'b1, 1'b1);
    cyc_in(1'b0, 1'b0);
    chk("s5_busy_second", 32'(busy),         32'd1);
    chk("s5_count_2",     32'(detect_count), 32'd2);

    // 6: 300 back-to-back detections saturate the counter.
    do_reset();
    cyc_in(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      cyc_in(1'b1, 1'b1);
      cyc_in(1'b1, 1'b1);
      repeat (30) cyc_in(1'b0, 1'b0);
      if (i == 254) chk("s6_count_255", 32'(detect_count), 32'd255);
    end
    chk("s6_count_sat", 32'(detect_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_beep_ctrl.md
Name: detect_beep_ctrl

Overview:
- Result-handling stage directly downstream of the DP word matcher (DP_main_mfc).
- Consumes the per-frame match strobe and flag, and qualifies a detection only after CONFIRM consecutive positive frames.
- On a qualified detection, drives the piezo with a square-wave tone for a fixed time, then holds off before re-arming.
- Also drives the status LEDs and a saturating detection counter; replaces ad-hoc beep logic in the top level.

Parameters:
- CONFIRM, 2: consecutive positive result frames required to trigger (1..15).
- TONE_HALF, 6250: clk cycles per tone half-period (4 kHz at 50 MHz), >=1.
- BEEP_CYCLES, 50000000: clk cycles the tone is emitted, >=1, <2^32.
- HOLDOFF_CYCLES, 5000000: clk cycles after the tone before re-arming, >=1, <2^32.

Ports:
- clk  in  1  global 50 MHz clock
- reset  in  1  asynchronous, active-low reset
- result_dv  in  1  one-cycle strobe: result is valid
- result  in  1  frame match flag from the DP stage
- vad_in  in  1  voice-activity flag from the DP stage
- beep  out  1  piezo drive; 0 when not beeping
- led_detect  out  1  last sampled result value
- led_vad  out  1  registered vad_in
- busy  out  1  1 in BEEP or HOLDOFF
- detect_count  out  8  qualified detections, saturates at 255

Behaviour:
- Reset (reset=0, async): state=IDLE; run, tone and timer counters =0.
  - All outputs =0, including beep, led_detect, led_vad, busy and detect_count.
- All outputs are registered. led_vad <= vad_in every cycle.
- led_detect <= result on every result_dv, in every state.
- Run counter (4 bit), IDLE only:
  - result_dv&result: run++.
  - result_dv&!result: run=0.
  - Falling edge of registered vad (1->0): run=0. This takes priority over a simultaneous increment.
- IDLE->BEEP:
  - Triggers on the cycle a result_dv&result makes run+1==CONFIRM.
  - On that same edge: run=0, timer=0, tone_cnt=0, detect_count increments (saturating), busy=1.
  - beep=1 is visible from the following cycle, i.e. 1 cycle latency from the strobe.
- BEEP:
  - tone_cnt counts 0..TONE_HALF-1. beep toggles each time tone_cnt wraps. The first half-period is high.
  - timer counts clk cycles in BEEP. After exactly BEEP_CYCLES cycles in BEEP, next state=HOLDOFF, beep=0, timer=0.
  - result_dv is ignored apart from led_detect.
- HOLDOFF:
  - beep=0, busy=1, run held at 0, result_dv ignored.
  - After HOLDOFF_CYCLES cycles, next state=IDLE and busy=0.
  - A result_dv arriving on the HOLDOFF->IDLE transition cycle is ignored.
- Mid-operation reset forces IDLE immediately, with beep=0 asynchronously.
- A result_dv strobe with result=1 on consecutive cycles counts each strobe; no minimum spacing is required.
- An illegal state encoding recovers to IDLE.
- Widths: 32-bit timer and tone counters. Comparisons use the parameter minus 1, computed at elaboration.

Decomposition:
- Shared package (detect_pkg):
  - State encoding IDLE/BEEP/HOLDOFF (2 bit).
  - Counter width constant (32).
  - Default timing constants for 50 MHz.
- One sub-module, tone_gen:
  - Enable-gated square-wave generator with a TONE_HALF parameter.
  - Synchronous clear on enable rise; output low when disabled.
- The FSM, run counter, timer and LED logic stay in the top.

Test Plan:
All scenarios use CONFIRM=2, TONE_HALF=3, BEEP_CYCLES=20, HOLDOFF_CYCLES=10.
1. Assert reset=0 mid-test with outputs active -> beep, busy, led_* and detect_count all 0 in the same cycle, without waiting for a clk edge.
2. Two strobes with result=1, 5 cycles apart -> busy=1 on the edge of the 2nd strobe. beep=1 the next cycle, then the pattern 1,1,1,0,0,0 repeating for 20 cycles. Then 10 cycles of beep=0 with busy=1, then busy=0. detect_count=1.
3. Strobe sequence 1,0,1 -> no beep, run=1 at the end. A further strobe with 1 -> beep starts, detect_count=1.
4. One positive strobe, vad_in falls 1->0, then one positive strobe -> no beep. A third positive strobe -> beep.
5. Four positive strobes during BEEP/HOLDOFF -> ignored and detect_count unchanged. led_detect follows each strobe. After return to IDLE, 2 positive strobes -> second beep, detect_count=2.
6. 300 qualified detections -> detect_count saturates at 255 and does not wrap.
